// File: rtl/store_trace_checker_if.sv
// Expected-store push channel and cpu store bus seen by store_trace_checker.
// master: bench/loader side drives pushes and the cpu store stream; slave: checker.
interface store_trace_checker_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          exp_valid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_ready;
    logic          memwrite;
    logic [AW-1:0] dataaddr;
    logic [DW-1:0] writedata;

    modport master (
        output exp_valid, exp_addr, exp_data,
        output memwrite, dataaddr, writedata,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_addr, exp_data,
        input  memwrite, dataaddr, writedata,
        output exp_ready
    );
endinterface

// File: rtl/store_trace_checker.sv
// In-order checker of cpu data-memory stores against a preloaded (addr,data) table.
// Ports: clk, resetn (async low), bus (push + store stream), start, clear, busy/done/pass, err_*, cycles.
module store_trace_checker #(
    parameter int DEPTH   = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter bit STRICT  = 1'b1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    store_trace_checker_if.slave  bus,
    input  logic                  start,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            err_code,
    output logic [CW-1:0]         err_idx,
    output logic [AW-1:0]         err_addr,
    output logic [DW-1:0]         err_data,
    output logic [31:0]           cycles
);
    // Table is rounded up to a power of two so pointer slices index it exactly.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NE = 1 << IW;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] rd_ptr_q;
    logic [TW-1:0] idle_q;
    logic [1:0]    err_code_q;
    logic [CW-1:0] err_idx_q;
    logic [AW-1:0] err_addr_q;
    logic [DW-1:0] err_data_q;
    logic [31:0]   cycles_q;
    logic [AW-1:0] addr_tab_q [NE];
    logic [DW-1:0] data_tab_q [NE];

    logic          push;
    logic          hit;
    logic          last;
    logic          tmo;
    logic [31:0]   cycles_d;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    assign bus.exp_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    assign push   = bus.exp_valid && bus.exp_ready;
    assign rd_idx = rd_ptr_q[IW-1:0];
    assign wr_idx = count_q[IW-1:0];
    assign hit    = (bus.dataaddr == addr_tab_q[rd_idx])
                 && (bus.writedata == data_tab_q[rd_idx]);
    assign last   = (rd_ptr_q + CW'(1)) == count_q;
    // Timeout fires on the cycle the idle count would reach TIMEOUT.
    assign tmo    = idle_q == TW'(TIMEOUT - 1);
    assign cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            idle_q     <= '0;
            err_code_q <= '0;
            err_idx_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
            cycles_q   <= '0;
            for (int i = 0; i < NE; i++) begin
                addr_tab_q[i] <= '0;
                data_tab_q[i] <= '0;
            end
        end else if (clear) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            idle_q     <= '0;
            err_code_q <= '0;
            err_idx_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
            cycles_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (push) begin
                        addr_tab_q[wr_idx] <= bus.exp_addr;
                        data_tab_q[wr_idx] <= bus.exp_data;
                        count_q            <= count_q + CW'(1);
                    end
                    // A push in the start cycle counts toward a non-empty table.
                    if (start && ((count_q != '0) || push)) begin
                        state_q  <= S_RUN;
                        rd_ptr_q <= '0;
                        idle_q   <= '0;
                        cycles_q <= '0;
                    end
                end
                S_RUN: begin
                    cycles_q <= cycles_d;
                    if (bus.memwrite) begin
                        if (hit) begin
                            rd_ptr_q <= rd_ptr_q + CW'(1);
                            idle_q   <= '0;
                            if (last) begin
                                state_q <= S_PASS;
                            end
                        end else begin
                            state_q    <= S_FAIL;
                            err_code_q <= 2'd1;
                            err_idx_q  <= rd_ptr_q;
                            err_addr_q <= bus.dataaddr;
                            err_data_q <= bus.writedata;
                        end
                    end else if (tmo) begin
                        state_q    <= S_FAIL;
                        err_code_q <= 2'd2;
                        err_idx_q  <= rd_ptr_q;
                        err_addr_q <= '0;
                        err_data_q <= '0;
                    end else begin
                        idle_q <= idle_q + TW'(1);
                    end
                end
                S_PASS: begin
                    if (STRICT && bus.memwrite) begin
                        state_q    <= S_FAIL;
                        err_code_q <= 2'd3;
                        err_idx_q  <= count_q;
                        err_addr_q <= bus.dataaddr;
                        err_data_q <= bus.writedata;
                    end
                end
                S_FAIL: begin
                    state_q <= S_FAIL;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass     = (state_q == S_PASS);
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;
    assign err_addr = err_addr_q;
    assign err_data = err_data_q;
    assign cycles   = cycles_q;
endmodule
